sample_display: RTL
===================

# sample_display

Downstream consumer of the 16-bit SPI read result. Edge-detects each new sample on `d_ready`, block-averages 2^AVG_LOG2 samples, converts the average to four BCD digits with a sequential double-dabble, and drives a time-multiplexed 4-digit common-anode seven-segment display. It sits beside the LED output in the SPI read top level and takes the same `d`/`d_ready` pair the LEDs use.

## Interface
- `AVG_LOG2`, default 3: log2 of samples per average. 0 passes each sample through.
- `SCAN_DIV`, default 100_000: clk cycles per digit slot, giving a 1 kHz digit rate at 100 MHz. Must be at least 2.
- `clk` in 1: system clock. All logic is on its rising edge.
- `rst_l` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `d` in 16: sample word. Stable whenever `d_ready` = 1 and in the `clk` domain.
- `d_ready` in 1: level from the SPI reader. The 0→1 transition marks a new sample.
- `avg` out 16: latest block average.
- `bcd_valid` out 1: one-cycle pulse when new digits are loaded.
- `overrun` out 1: sticky. Set when a block completes while the converter is busy.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp` out 1: decimal point, active-low.
- `an` out 4: digit anodes, active-low one-hot. Bit 0 is the rightmost digit.

## Operation
- Capture: `d_ready_q` is registered. Capture when `d_ready && !d_ready_q`. A level held high yields one capture.
- Accumulator: width 16+AVG_LOG2, plus a sample counter.
  - On the 2^AVG_LOG2-th capture: `avg <= (acc + d) >> AVG_LOG2` (truncating), acc cleared, counter cleared, conversion requested.
- Converter FSM:
  - IDLE → SHIFT on request, loading `avg`.
  - SHIFT runs 16 iterations of add-3-then-shift into a 20-bit BCD register.
  - SHIFT → LOAD after iteration 16.
  - LOAD → IDLE, writing the digit registers and pulsing `bcd_valid`.
- Overflow: if the BCD result is ≥ 10000, display 9,9,9,9 with all four dp lit. Otherwise all dp are off.
- Busy collision: a request arriving in SHIFT or LOAD is dropped; `avg` still updates; `overrun` <= 1. The accumulator keeps running independently.
- Scan: a divider counts 0..SCAN_DIV-1. At wrap the digit index advances 0→1→2→3→0. `an` = ~(1 << index).
- Leading-zero blanking: digits 3..1 blank (seg = 7'h7F) while they and all higher digits are zero. Digit 0 is always shown.
- Before the first LOAD after reset, `an` = 4'hF (display dark) and the scan still runs.
- Reset values: `avg` = 0, `bcd_valid` = 0, `overrun` = 0, `seg` = 7'h7F, `dp` = 1, `an` = 4'hF, FSM = IDLE, acc/counters/index = 0, digit registers = 0.
- Reset mid-conversion aborts; no `bcd_valid` is issued.

## Timing
- Capture edge seen at cycle t → accumulator updated at t+1.
- Final-sample capture at t → `avg` valid at t+1 → SHIFT cycles t+1..t+16 → LOAD at t+17 → `bcd_valid` high during cycle t+18 only. Digit registers hold new values from t+18.
- Minimum spacing between completed blocks without overrun: 18 cycles.
- `seg`/`dp`/`an` are registered and change one cycle after an index change or a digit-register update. There is no mid-slot glitch: all three update together.
- Simultaneous capture and conversion LOAD: both take effect. The accumulator and converter are independent.

## Structure
- Shared package `display_pkg` holds:
  - Converter state enum (IDLE, SHIFT, LOAD).
  - Seven-segment patterns for 0-9.
  - `SEG_BLANK` = 7'h7F.
  - BCD width constant of 20.
- Sub-module `bin2bcd_seq`: 16-bit sequential double-dabble with start/busy/done and 20-bit output. The top level holds capture, accumulator, overflow clamp and scan.

## Test plan
- AVG_LOG2=0, single pulse d=16'd1234 → `bcd_valid` 18 cycles after the edge. Digits show 1,2,3,4 across slots; `an` cycles E,D,B,7; `dp` all 1.
- AVG_LOG2=2, samples 100,101,102,103 → `avg` = 101 (truncate 406/4). Digit 3 blank; digits show 1,0,1.
- AVG_LOG2=0, d=16'd65535 → `avg` = 65535. Display 9999 with `dp` = 0 in every slot.
- Two completed blocks 5 cycles apart (AVG_LOG2=0) → second `avg` updates, no second `bcd_valid`, `overrun` = 1 until reset.
- `d_ready` held high for 1000 cycles → exactly one capture. Assert `rst_l` low mid-SHIFT → all outputs at reset values immediately; no `bcd_valid` afterwards.
- Before any sample after reset, run 4×SCAN_DIV cycles → `an` stays 4'hF and `seg` stays 7'h7F.

Source files
------------

// File: rtl/display_pkg.sv
// Shared converter state, BCD width and seven-segment patterns for the
// sample display path.
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LOAD
  } conv_state_t;

  localparam int BCD_W = 20;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; entry n is the glyph for digit n.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    if (digit > 4'd9) return SEG_BLANK;
    return SEG_DIGITS[digit];
  endfunction

endpackage

// File: rtl/sample_display_bin2bcd.sv
// Sequential double-dabble: converts a 16-bit word into five BCD digits,
// one add-3-then-shift iteration per clock.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic             clk,
  input  logic             rst_l,
  input  logic             start,
  input  logic [15:0]      bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  conv_state_t      state;
  logic [15:0]      bin_sh;
  logic [3:0]       iter;
  logic [BCD_W-1:0] bcd_adj;

  // Any nibble of 5 or more gets +3 so the following shift carries correctly.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state  <= ST_IDLE;
      bin_sh <= '0;
      iter   <= '0;
      bcd    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            bin_sh <= bin;
            bcd    <= '0;
            iter   <= '0;
            busy   <= 1'b1;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {bcd, bin_sh} <= {bcd_adj, bin_sh} << 1;
          iter          <= iter + 4'd1;
          if (iter == 4'd15) begin
            done  <= 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/sample_display.sv
// Block-averages SPI samples, converts the average to BCD and scans it
// onto a 4-digit common-anode seven-segment display.
module sample_display
  import display_pkg::*;
#(
  parameter int AVG_LOG2 = 3,
  parameter int SCAN_DIV = 100_000
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic [15:0] d,
  input  logic        d_ready,
  output logic [15:0] avg,
  output logic        bcd_valid,
  output logic        overrun,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int ACC_W = 16 + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic             d_ready_q;
  logic             capture;
  logic             last;
  logic             start;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      avg_next;

  logic             conv_busy;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;

  logic [3:0][3:0]  dig;
  logic             ovf;
  logic             lit;

  logic [DIV_W-1:0] div;
  logic [1:0]       idx;
  logic             blank;
  logic [6:0]       seg_next;

  // Anything of 10000 or more is shown as 9999 with every decimal point lit.
  function automatic logic [16:0] clamp_digits(input logic [BCD_W-1:0] b);
    if (b[19:16] != 4'd0) return {1'b1, 16'h9999};
    return {1'b0, b[15:0]};
  endfunction

  // Capture stage: the rising edge of d_ready marks one new sample
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) d_ready_q <= 1'b0;
    else        d_ready_q <= d_ready;
  end

  assign capture  = d_ready && !d_ready_q;
  assign last     = (cnt == CNT_LAST);
  assign sum      = acc + ACC_W'(d);
  assign avg_next = 16'(sum >> AVG_LOG2);
  assign start    = capture && last;

  // Accumulate stage: the final sample of a block is folded in directly
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      acc     <= '0;
      cnt     <= '0;
      avg     <= '0;
      overrun <= 1'b0;
    end else if (capture) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
        avg <= avg_next;
        if (conv_busy) overrun <= 1'b1;
      end else begin
        acc <= sum;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst_l (rst_l),
    .start (start),
    .bin   (avg_next),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Digit stage: latch the converted (and clamped) result
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      dig       <= '0;
      ovf       <= 1'b0;
      lit       <= 1'b0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= conv_done;
      if (conv_done) begin
        {ovf, dig} <= clamp_digits(conv_bcd);
        lit        <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      div <= '0;
      idx <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
      idx <= idx + 2'd1;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Leading zeros stay dark; the rightmost digit is always shown.
  always_comb begin
    blank = 1'b0;
    case (idx)
      2'd3:    blank = (dig[3] == 4'd0);
      2'd2:    blank = (dig[3] == 4'd0) && (dig[2] == 4'd0);
      2'd1:    blank = (dig[3] == 4'd0) && (dig[2] == 4'd0) && (dig[1] == 4'd0);
      default: blank = 1'b0;
    endcase
    seg_next = blank ? SEG_BLANK : seg_encode(dig[idx]);
  end

  // Drive stage: seg, dp and an are registered together
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= 4'hF;
    end else if (!lit) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= 4'hF;
    end else begin
      seg <= seg_next;
      dp  <= !ovf;
      an  <= ~(4'b0001 << idx);
    end
  end

endmodule
